// File: rtl/dcache_axi_pkg.sv
// Shared definitions for the data-cache to AXI4 bridge.
//   - Line geometry, derived from the cache geometry macro DCACHE_B
//     (log2 of the line size in bytes).
//   - AXI4 encodings used by the bridge (INCR burst, 32-bit beats, OKAY).
//   - Bridge FSM state encoding.
//   - line_align(): clears the byte-in-line offset of an address.
`ifndef DCACHE_B
`define DCACHE_B 5
`endif

package dcache_axi_pkg;

  localparam int unsigned DCACHE_LINE_WORDS = 2 ** (`DCACHE_B - 2);

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] STRB_FULL  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5
  } state_e;

  // Line-align an address for a line of 'words' 32-bit words.
  function automatic logic [31:0] line_align(input logic [31:0] addr,
                                             input int unsigned words);
    logic [31:0] mask_s;
    mask_s = (32'(words) << 2) - 32'd1;
    return addr & ~mask_s;
  endfunction

endpackage

// File: rtl/dcache_axi_bridge.sv
// Data-cache to AXI4 bridge. Turns line refill / dirty writeback requests
// into single AXI4 INCR bursts of LINE_WORDS 32-bit beats, one transaction
// at a time.
// Ports:
//   clk, reset (async, active-low)
//   cache side : cache_req, cache_wen, cache_addr, cache_wdata, cache_wlast,
//                cache_awvalid in; cache_addr_ok, cache_data_ok, cache_rdata out
//   AXI AR/R   : arid, araddr, arlen, arsize, arburst, arvalid / arready;
//                rdata, rresp, rlast, rvalid / rready
//   AXI AW/W/B : awid, awaddr, awlen, awsize, awburst, awvalid / awready;
//                wdata, wstrb, wlast, wvalid / wready; bresp, bvalid / bready
//   bus_err    : sticky flag, set by any non-OKAY rresp or bresp
module dcache_axi_bridge
  import dcache_axi_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DCACHE_LINE_WORDS,
  parameter logic [3:0]  AXI_ID     = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cache_req,
  input  logic        cache_wen,
  input  logic [31:0] cache_addr,
  input  logic [31:0] cache_wdata,
  input  logic        cache_wlast,
  input  logic        cache_awvalid,
  output logic        cache_addr_ok,
  output logic        cache_data_ok,
  output logic [31:0] cache_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        bus_err
);

  localparam int unsigned      CNT_W     = $clog2(LINE_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [7:0]       BURST_LEN = 8'(LINE_WORDS - 1);

  state_e           state_r;
  logic [31:0]      addr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             arvalid_r;
  logic             rready_r;
  logic             awvalid_r;
  logic             wvalid_r;
  logic             bready_r;
  logic             bus_err_r;
  logic             last_wbeat_s;

  // The counter caps the burst even if the cache never flags its last word.
  assign last_wbeat_s = (cnt_r == LAST_BEAT) || cache_wlast;

  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign araddr  = addr_r;
  assign awaddr  = addr_r;
  assign arlen   = BURST_LEN;
  assign awlen   = BURST_LEN;
  assign arsize  = SIZE_WORD;
  assign awsize  = SIZE_WORD;
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign wstrb   = STRB_FULL;
  assign arvalid = arvalid_r;
  assign rready  = rready_r;
  assign awvalid = awvalid_r;
  assign wvalid  = wvalid_r;
  assign bready  = bready_r;
  assign bus_err = bus_err_r;

  // Handshake pulses and beat data are passed through with zero added latency.
  always_comb begin
    cache_addr_ok = 1'b0;
    cache_data_ok = 1'b0;
    cache_rdata   = 32'd0;
    wdata         = 32'd0;
    wlast         = 1'b0;
    if (arvalid_r) begin
      cache_addr_ok = arready;
    end else if (awvalid_r) begin
      cache_addr_ok = awready;
    end else begin
      cache_addr_ok = 1'b0;
    end
    if (rready_r) begin
      cache_data_ok = rvalid;
      cache_rdata   = rdata;
    end else if (wvalid_r) begin
      cache_data_ok = wready;
      wdata         = cache_wdata;
      wlast         = last_wbeat_s;
    end else begin
      cache_data_ok = 1'b0;
    end
  end

  // Transaction FSM with registered channel valid/ready outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      addr_r    <= 32'd0;
      cnt_r     <= CNT_ZERO;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A pending writeback takes priority over a refill.
          if (cache_req && (cache_wen || cache_awvalid)) begin
            addr_r    <= line_align(cache_addr, LINE_WORDS);
            awvalid_r <= 1'b1;
            state_r   <= ST_AW;
          end else if (cache_req && !cache_wen) begin
            addr_r    <= line_align(cache_addr, LINE_WORDS);
            arvalid_r <= 1'b1;
            state_r   <= ST_AR;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            cnt_r     <= CNT_ZERO;
            state_r   <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            if (rresp != RESP_OKAY) begin
              bus_err_r <= 1'b1;
            end
            // An early rlast ends the burst; the counter bounds a missing one.
            if (rlast || (cnt_r == LAST_BEAT)) begin
              rready_r <= 1'b0;
              state_r  <= ST_IDLE;
            end else begin
              cnt_r    <= cnt_r + CNT_ONE;
            end
          end
        end
        ST_AW: begin
          if (awready) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b1;
            cnt_r     <= CNT_ZERO;
            state_r   <= ST_W;
          end
        end
        ST_W: begin
          if (wready) begin
            if (last_wbeat_s) begin
              wvalid_r <= 1'b0;
              bready_r <= 1'b1;
              state_r  <= ST_B;
            end else begin
              cnt_r    <= cnt_r + CNT_ONE;
            end
          end
        end
        ST_B: begin
          if (bvalid) begin
            if (bresp != RESP_OKAY) begin
              bus_err_r <= 1'b1;
            end
            bready_r <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Self-checking bench for dcache_axi_bridge: directed scenarios followed by
// randomized refills/writebacks, checked against expectations computed from
// the bridge's transfer rules (line alignment, beat counts, sticky error).
module tb_dcache_axi_bridge;

  localparam int unsigned LW = 8;

  logic        clk;
  logic        reset;
  logic        cache_req;
  logic        cache_wen;
  logic [31:0] cache_addr;
  logic [31:0] cache_wdata;
  logic        cache_wlast;
  logic        cache_awvalid;
  logic        cache_addr_ok;
  logic        cache_data_ok;
  logic [31:0] cache_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        bus_err;

  int   n_cmp;
  int   n_err;
  logic exp_err;

  dcache_axi_bridge #(.LINE_WORDS(LW), .AXI_ID(4'd1)) dut (
    .clk(clk), .reset(reset),
    .cache_req(cache_req), .cache_wen(cache_wen), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_wlast(cache_wlast),
    .cache_awvalid(cache_awvalid), .cache_addr_ok(cache_addr_ok),
    .cache_data_ok(cache_data_ok), .cache_rdata(cache_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_arvalid"}, 32'(arvalid), 32'd0);
    check({tag, "_rready"},  32'(rready),  32'd0);
    check({tag, "_awvalid"}, 32'(awvalid), 32'd0);
    check({tag, "_wvalid"},  32'(wvalid),  32'd0);
    check({tag, "_bready"},  32'(bready),  32'd0);
    check({tag, "_addr_ok"}, 32'(cache_addr_ok), 32'd0);
    check({tag, "_data_ok"}, 32'(cache_data_ok), 32'd0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'(exp_err));
  endtask

  // rlast_at: 0 = rlast on the final beat, -1 = never, 1..LW-1 = early end.
  task automatic do_refill(input logic [31:0] addr, input int ar_dly,
                           input int rlast_at, input int unsigned gap_pct,
                           input int err_beat);
    logic [31:0] exp_addr;
    logic [31:0] word;
    int exp_beats;
    int got;
    int cyc;
    exp_addr  = addr & ~(32'(LW * 4) - 32'd1);
    exp_beats = (rlast_at > 0 && rlast_at < int'(LW)) ? rlast_at : int'(LW);
    cache_req = 1'b1; cache_wen = 1'b0; cache_awvalid = 1'b0; cache_addr = addr;
    tick();
    cache_req = 1'b0; cache_addr = $urandom;
    for (int i = 0; i < ar_dly; i++) begin
      arready = 1'b0;
      #1;
      check("ar_wait_valid", 32'(arvalid), 32'd1);
      check("ar_wait_addr_ok", 32'(cache_addr_ok), 32'd0);
      check("ar_wait_addr", araddr, exp_addr);
      tick();
    end
    arready = 1'b1;
    #1;
    check("ar_valid", 32'(arvalid), 32'd1);
    check("ar_addr", araddr, exp_addr);
    check("ar_len", 32'(arlen), 32'(LW - 1));
    check("ar_size", 32'(arsize), 32'd2);
    check("ar_burst", 32'(arburst), 32'd1);
    check("ar_id", 32'(arid), 32'd1);
    check("ar_addr_ok", 32'(cache_addr_ok), 32'd1);
    check("ar_no_aw", 32'(awvalid), 32'd0);
    tick();
    arready = 1'b0;
    got = 0; cyc = 0;
    while (got < exp_beats && cyc < 200) begin
      rvalid = ($urandom_range(99) >= gap_pct);
      word   = $urandom;
      rdata  = word;
      rlast  = (rlast_at != -1) && (got + 1 == exp_beats);
      rresp  = (got == err_beat) ? 2'b10 : 2'b00;
      #1;
      check("r_ready", 32'(rready), 32'd1);
      check("r_addr_ok", 32'(cache_addr_ok), 32'd0);
      check("r_data_ok", 32'(cache_data_ok), 32'(rvalid));
      if (rvalid) begin
        check("r_rdata", cache_rdata, word);
        if (rresp != 2'b00) exp_err = 1'b1;
        got++;
      end
      tick();
      cyc++;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    check("r_beats", 32'(got), 32'(exp_beats));
    #1;
    check_all_idle("r_done");
  endtask

  task automatic do_wb(input logic [31:0] addr, input logic wen,
                       input logic awv, input int aw_dly, input int wmode,
                       input int b_dly, input logic [1:0] bresp_v,
                       input logic use_cwlast, input logic seq,
                       input logic [31:0] base, input int abort_beat);
    logic [31:0] exp_addr;
    logic [31:0] data [LW];
    logic wtog;
    int k;
    int cyc;
    exp_addr = addr & ~(32'(LW * 4) - 32'd1);
    for (int i = 0; i < int'(LW); i++) data[i] = seq ? base + 32'(i) : $urandom;
    cache_req = 1'b1; cache_wen = wen; cache_awvalid = awv; cache_addr = addr;
    tick();
    cache_req = 1'b0; cache_awvalid = 1'b0; cache_addr = $urandom;
    for (int i = 0; i < aw_dly; i++) begin
      awready = 1'b0;
      #1;
      check("aw_wait_valid", 32'(awvalid), 32'd1);
      check("aw_wait_addr_ok", 32'(cache_addr_ok), 32'd0);
      check("aw_wait_no_ar", 32'(arvalid), 32'd0);
      tick();
    end
    awready = 1'b1;
    #1;
    check("aw_valid", 32'(awvalid), 32'd1);
    check("aw_addr", awaddr, exp_addr);
    check("aw_len", 32'(awlen), 32'(LW - 1));
    check("aw_size", 32'(awsize), 32'd2);
    check("aw_burst", 32'(awburst), 32'd1);
    check("aw_id", 32'(awid), 32'd1);
    check("aw_addr_ok", 32'(cache_addr_ok), 32'd1);
    check("aw_no_ar", 32'(arvalid), 32'd0);
    tick();
    awready = 1'b0;
    k = 0; cyc = 0; wtog = 1'b1;
    while (k < int'(LW) && cyc < 200) begin
      cache_wdata = data[k];
      cache_wlast = use_cwlast && (k == int'(LW) - 1);
      wready = (wmode == 0) ? wtog : 1'($urandom_range(1));
      wtog = ~wtog;
      #1;
      if (k == abort_beat) begin
        reset = 1'b0;
        exp_err = 1'b0;
        #1;
        check_all_idle("rst_async");
        check("rst_async_wlast", 32'(wlast), 32'd0);
        tick();
        check_all_idle("rst_edge");
        reset = 1'b1;
        wready = 1'b0; cache_wlast = 1'b0;
        tick();
        check_all_idle("rst_release");
        return;
      end
      check("w_valid", 32'(wvalid), 32'd1);
      check("w_data", wdata, data[k]);
      check("w_last", 32'(wlast), 32'(k == int'(LW) - 1));
      check("w_strb", 32'(wstrb), 32'hF);
      check("w_data_ok", 32'(cache_data_ok), 32'(wready));
      check("w_no_ar", 32'(arvalid), 32'd0);
      tick();
      if (wready) k++;
      cyc++;
    end
    wready = 1'b0; cache_wlast = 1'b0;
    check("w_beats", 32'(k), 32'(LW));
    for (int i = 0; i < b_dly; i++) begin
      bvalid = 1'b0;
      #1;
      check("b_wait_ready", 32'(bready), 32'd1);
      check("b_wait_no_w", 32'(wvalid), 32'd0);
      check("b_wait_data_ok", 32'(cache_data_ok), 32'd0);
      tick();
    end
    bvalid = 1'b1; bresp = bresp_v;
    #1;
    check("b_ready", 32'(bready), 32'd1);
    check("b_data_ok", 32'(cache_data_ok), 32'd0);
    check("b_no_ar", 32'(arvalid), 32'd0);
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    if (bresp_v != 2'b00) exp_err = 1'b1;
    #1;
    check_all_idle("b_done");
  endtask

  initial begin
    int kind;
    int r;
    n_cmp = 0; n_err = 0; exp_err = 1'b0;
    reset = 1'b0;
    cache_req = 1'b0; cache_wen = 1'b0; cache_addr = 32'd0;
    cache_wdata = 32'd0; cache_wlast = 1'b0; cache_awvalid = 1'b0;
    arready = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    tick(); tick();
    check_all_idle("reset");
    reset = 1'b1;
    tick();
    check_all_idle("post_reset");

    // Refill at 0x1FC0_0024, arready after 2 cycles, every-cycle rvalid.
    do_refill(32'h1FC0_0024, 2, 0, 0, -1);
    // Writeback A0..A7 at 0x1040, wready toggling, bvalid after 3 cycles.
    do_wb(32'h0000_1040, 1'b1, 1'b0, 0, 0, 3, 2'b00, 1'b0, 1'b1, 32'hA0, -1);
    // Writeback pending alongside a refill request: AW first, AR afterwards.
    do_wb(32'h0000_2000, 1'b0, 1'b1, 1, 1, 1, 2'b00, 1'b1, 1'b0, 32'd0, -1);
    do_refill(32'h0000_2000, 0, 0, 0, -1);
    // Early rlast on beat 4, then a normal refill with no rlast at all.
    do_refill(32'h8000_0100, 1, 4, 0, -1);
    do_refill(32'h8000_0140, 0, -1, 30, -1);
    // Error response is sticky through a later OKAY refill.
    do_wb(32'h0000_3000, 1'b1, 1'b0, 0, 1, 0, 2'b10, 1'b0, 1'b0, 32'd0, -1);
    do_refill(32'h0000_3020, 0, 0, 0, -1);
    // Reset during W beat 3 abandons the burst; a later refill is clean.
    do_wb(32'h0000_4000, 1'b1, 1'b0, 1, 0, 0, 2'b00, 1'b0, 1'b0, 32'd0, 3);
    do_refill(32'h0000_4000, 1, 0, 0, -1);

    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(1));
      if (kind == 0) begin
        r = int'($urandom_range(LW + 2));
        do_refill($urandom, int'($urandom_range(3)),
                  (r > int'(LW)) ? 0 : ((r == int'(LW)) ? -1 : r),
                  $urandom_range(50),
                  ($urandom_range(9) == 0) ? int'($urandom_range(LW - 1)) : -1);
      end else begin
        do_wb($urandom, 1'b1, 1'($urandom_range(1)), int'($urandom_range(3)),
              int'($urandom_range(1)), int'($urandom_range(3)),
              ($urandom_range(9) == 0) ? 2'b11 : 2'b00,
              1'($urandom_range(1)), 1'b0, 32'd0, -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
